fp_multiply_pipe: RTL and testbench
===================================

Name: fp_multiply_pipe

Overview:
- Parametrised, fully pipelined IEEE-754-style floating-point multiplier; next generation of the single-precision multiplier in the ASR feature datapath.
- Adds valid/ready handshake with backpressure, special-value handling (zero/inf/NaN), overflow/underflow/invalid flags and round-to-nearest-even.
- Sits between feature-extraction arithmetic stages (filterbank/MFCC MAC chains); one result per cycle sustained.

Parameters:
- EXP_WIDTH, 8, exponent field width; bias = 2^(EXP_WIDTH-1)-1.
- MANT_WIDTH, 23, stored significand width (hidden bit excluded).
- DATA_WIDTH (localparam), 1+EXP_WIDTH+MANT_WIDTH, operand/result width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block accepts operands this cycle.
- in_a  input  DATA_WIDTH  factor A.
- in_b  input  DATA_WIDTH  factor B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_product  output  DATA_WIDTH  A*B.
- out_flags  output  3  {invalid, overflow, underflow}, qualified by out_valid.

Behaviour:
- Reset: one clk, synchronous, active-high. All stage valid bits, out_valid, out_product, out_flags clear to 0. Mid-operation reset discards in-flight data; in_ready is 1 the cycle after rst deasserts.
- Pipeline: S1 unpack/classify/sign XOR/exponent sum; S2 (MANT_WIDTH+1)^2 significand product; S3 normalise/round/pack/flags. Latency 3 cycles from accepted input to out_valid when unstalled.
- Global stall: adv = !out_valid || out_ready; in_ready = adv. All stages advance only when adv. Transfer on in_valid&&in_ready and on out_valid&&out_ready. Bubbles propagate as invalid stages. Order is preserved and no data is lost or duplicated under any out_ready pattern.
- Classification: exp==0 -> zero (subnormal inputs flushed to signed zero). exp==all-ones with mant==0 -> inf. exp==all-ones with mant!=0 -> NaN.
- Special cases, priority order:
  - NaN operand, or zero*inf -> canonical quiet NaN (sign 0, exp all-ones, mant MSB 1, rest 0). invalid=1 only for zero*inf.
  - inf operand -> signed inf.
  - zero operand -> signed zero (sign = sA^sB).
- Exponent: signed EXP_WIDTH+2 bits, e = eA+eB-bias. Product MSB set -> shift right 1 and e+1.
- Rounding: guard/round/sticky from discarded product bits. Rounding carry-out renormalises, e+1.
- e >= all-ones -> signed inf, overflow=1. e <= 0 -> signed zero, underflow=1 (no subnormal output).
- Flags are 0 for all other results.

Optional Feature:
- FPM_ROUND_NEAREST_EN.
- Defined: round-to-nearest, ties-to-even, as in Behaviour.
- Undefined: truncation (round toward zero); guard/sticky logic omitted. Overflow then saturates to max finite (exp all-ones minus 1, mant all-ones) with overflow=1 instead of inf.
- Latency and handshake are identical in both builds.

Decomposition:
- Package fp_pkg:
  - fp class enum {FP_ZERO, FP_NORM, FP_INF, FP_NAN}.
  - flag bit index constants.
  - bias/qNaN/inf pattern functions of EXP_WIDTH/MANT_WIDTH.
- Sub-module fp_round_pack: S3 combinational normalise/round/pack/flags. Reusable by a future adder.

Test Plan:
- 0x40000000 * 0x40400000 (2.0*3.0) -> 0x40C00000, flags 0, out_valid exactly 3 cycles after accept.
- 0xC1560000 * 0x40000000 (-13.375*2.0) -> 0xC1D60000. Also 0x00000000 * 0xC0000000 -> 0x80000000.
- 0x00000000 * 0x7F800000 -> 0x7FC00000, invalid=1. 0x7F000000 * 0x7F000000 -> 0x7F800000, overflow=1 (truncation build: 0x7F7FFFFF). 0x00800000 * 0x3F000000 -> 0x00000000, underflow=1.
- 0x3FC00001 * 0x3FC00001 -> 0x40100002 with FPM_ROUND_NEAREST_EN; 0x40100001 without.
- Stream 10 back-to-back pairs; hold out_ready low cycles 4-8 -> in_ready low while stalled, all 10 results in order, none dropped or duplicated.
- Assert rst for 1 cycle with 2 ops in flight -> out_valid 0 next cycle, no stale result later; new op after reset returns correctly in 3 cycles.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared floating-point definitions (operand classes, flag bit
// positions, and bias / special-pattern builders sized by exponent and
// significand widths).
package fp_pkg;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;

    // Bit positions inside the 3-bit {invalid, overflow, underflow} flag word
    localparam int FLAG_INVALID   = 2;
    localparam int FLAG_OVERFLOW  = 1;
    localparam int FLAG_UNDERFLOW = 0;

    function automatic int fp_bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    // Exponent all-ones, significand zero, sign bit clear
    function automatic logic [63:0] fp_inf_pattern(input int ew, input int mw);
        return ((64'd1 << ew) - 64'd1) << mw;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all-ones, only significand MSB set
    function automatic logic [63:0] fp_qnan_pattern(input int ew, input int mw);
        return fp_inf_pattern(ew, mw) | (64'd1 << (mw - 1));
    endfunction

    // Largest finite magnitude: exponent all-ones minus one, significand all-ones
    function automatic logic [63:0] fp_max_finite_pattern(input int ew, input int mw);
        return (((64'd1 << ew) - 64'd2) << mw) | ((64'd1 << mw) - 64'd1);
    endfunction

    function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                              input logic mant_nz);
        if (exp_zero)
            return FP_ZERO;
        else if (exp_ones)
            return mant_nz ? FP_NAN : FP_INF;
        else
            return FP_NORM;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// fp_round_pack: combinational normalise / round / pack / flag stage.
// Build option FPM_ROUND_NEAREST_EN selects round-to-nearest-even; without
// it the significand is truncated and overflow saturates to max finite.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    localparam int DATA_WIDTH = 1 + EXP_WIDTH + MANT_WIDTH,
    localparam int PW         = 2 * (MANT_WIDTH + 1)
) (
    input  logic                    i_sign,
    input  logic signed [EXP_WIDTH+1:0] i_exp,
    input  logic [PW-1:0]           i_prod,
    input  logic                    i_special,
    input  logic [DATA_WIDTH-1:0]   i_special_val,
    input  logic [2:0]              i_special_flags,
    output logic [DATA_WIDTH-1:0]   o_result,
    output logic [2:0]              o_flags
);

    localparam logic signed [EXP_WIDTH+1:0] ONE_E      = {{(EXP_WIDTH+1){1'b0}}, 1'b1};
    localparam logic signed [EXP_WIDTH+1:0] ZERO_S     = '0;
    localparam logic signed [EXP_WIDTH+1:0] EXP_ONES_S = {2'b00, {EXP_WIDTH{1'b1}}};
`ifdef FPM_ROUND_NEAREST_EN
    localparam logic [63:0] OVF_P = fp_inf_pattern(EXP_WIDTH, MANT_WIDTH);
`else
    localparam logic [63:0] OVF_P = fp_max_finite_pattern(EXP_WIDTH, MANT_WIDTH);
`endif

    logic [PW-1:0]               w_norm;
    logic signed [EXP_WIDTH+1:0] w_exp_norm;
    logic signed [EXP_WIDTH+1:0] w_exp_final;
    logic [MANT_WIDTH-1:0]       w_mant;
    logic                        w_round_up;
    logic [MANT_WIDTH:0]         w_mant_rnd;
    logic                        w_unused_bits;
`ifdef FPM_ROUND_NEAREST_EN
    logic                        w_guard;
    logic                        w_sticky;
`endif

    // Hidden bit is always set for normal inputs; low bits feed rounding only
    assign w_unused_bits = ^{w_norm[PW-1], w_norm[PW-2-MANT_WIDTH:0]};

    // Normalise the [1,4) product, round, then apply exponent range checks
    always_comb begin
        w_norm     = i_prod[PW-1] ? i_prod : (i_prod << 1);
        w_exp_norm = i_prod[PW-1] ? (i_exp + ONE_E) : i_exp;
        w_mant     = w_norm[PW-2 -: MANT_WIDTH];
`ifdef FPM_ROUND_NEAREST_EN
        w_guard    = w_norm[PW-2-MANT_WIDTH];
        w_sticky   = |w_norm[PW-3-MANT_WIDTH:0];
        w_round_up = w_guard && (w_sticky || w_mant[0]);
`else
        w_round_up = 1'b0;
`endif
        // A carry out of the rounded significand leaves the field at zero
        w_mant_rnd  = {1'b0, w_mant} + {{MANT_WIDTH{1'b0}}, w_round_up};
        w_exp_final = w_mant_rnd[MANT_WIDTH] ? (w_exp_norm + ONE_E) : w_exp_norm;

        o_result = {i_sign, w_exp_final[EXP_WIDTH-1:0], w_mant_rnd[MANT_WIDTH-1:0]};
        o_flags  = '0;
        if (i_special) begin
            o_result = i_special_val;
            o_flags  = i_special_flags;
        end else if (w_exp_final >= EXP_ONES_S) begin
            o_result = {i_sign, OVF_P[DATA_WIDTH-2:0]};
            o_flags[FLAG_OVERFLOW] = 1'b1;
        end else if (w_exp_final <= ZERO_S) begin
            o_result = {i_sign, {(DATA_WIDTH-1){1'b0}}};
            o_flags[FLAG_UNDERFLOW] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_multiply_pipe.sv
// fp_multiply_pipe: 3-stage pipelined floating-point multiplier.
// Build option FPM_ROUND_NEAREST_EN: round-to-nearest-even (default: truncate).
// Handshake: a transfer occurs on any cycle where valid and ready are both
// high. All stages move together on adv = !out_valid || out_ready, and
// in_ready is adv itself, so a stalled output freezes the whole pipe.
module fp_multiply_pipe
    import fp_pkg::*;
#(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    localparam int DATA_WIDTH = 1 + EXP_WIDTH + MANT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_product,
    output logic [2:0]            out_flags
);

    localparam int EW2 = EXP_WIDTH + 2;
    localparam int PW  = 2 * (MANT_WIDTH + 1);
    localparam logic [63:0] INF_P  = fp_inf_pattern(EXP_WIDTH, MANT_WIDTH);
    localparam logic [63:0] QNAN_P = fp_qnan_pattern(EXP_WIDTH, MANT_WIDTH);
    localparam logic signed [EW2-1:0] BIAS_S = EW2'(fp_bias(EXP_WIDTH));

    logic                   w_adv;
    logic [EXP_WIDTH-1:0]   w_exp_a, w_exp_b;
    logic [MANT_WIDTH-1:0]  w_man_a, w_man_b;
    fp_class_e              w_cls_a, w_cls_b;
    logic                   w_sign;
    logic signed [EW2-1:0]  w_exp_sum;
    logic                   w_special;
    logic [DATA_WIDTH-1:0]  w_spec_val;
    logic [2:0]             w_spec_flags;
    logic [PW-1:0]          w_prod;
    logic [DATA_WIDTH-1:0]  w_result;
    logic [2:0]             w_flags;

    logic                   r1_valid, r1_sign, r1_special;
    logic signed [EW2-1:0]  r1_exp;
    logic [MANT_WIDTH:0]    r1_sig_a, r1_sig_b;
    logic [DATA_WIDTH-1:0]  r1_spec_val;
    logic [2:0]             r1_spec_flags;

    logic                   r2_valid, r2_sign, r2_special;
    logic signed [EW2-1:0]  r2_exp;
    logic [PW-1:0]          r2_prod;
    logic [DATA_WIDTH-1:0]  r2_spec_val;
    logic [2:0]             r2_spec_flags;

    logic                   r_out_valid;
    logic [DATA_WIDTH-1:0]  r_out_product;
    logic [2:0]             r_out_flags;

    assign w_adv       = !r_out_valid || out_ready;
    assign in_ready    = w_adv;
    assign out_valid   = r_out_valid;
    assign out_product = r_out_product;
    assign out_flags   = r_out_flags;

    // Stage 1 logic: unpack, classify, sign/exponent, resolve special operands
    always_comb begin
        w_exp_a   = in_a[DATA_WIDTH-2 -: EXP_WIDTH];
        w_exp_b   = in_b[DATA_WIDTH-2 -: EXP_WIDTH];
        w_man_a   = in_a[MANT_WIDTH-1:0];
        w_man_b   = in_b[MANT_WIDTH-1:0];
        w_cls_a   = fp_classify(w_exp_a == '0, w_exp_a == '1, w_man_a != '0);
        w_cls_b   = fp_classify(w_exp_b == '0, w_exp_b == '1, w_man_b != '0);
        w_sign    = in_a[DATA_WIDTH-1] ^ in_b[DATA_WIDTH-1];
        w_exp_sum = $signed({2'b00, w_exp_a}) + $signed({2'b00, w_exp_b}) - BIAS_S;

        w_special    = 1'b1;
        w_spec_val   = '0;
        w_spec_flags = '0;
        if (w_cls_a == FP_NAN || w_cls_b == FP_NAN) begin
            w_spec_val = QNAN_P[DATA_WIDTH-1:0];
        end else if ((w_cls_a == FP_ZERO && w_cls_b == FP_INF) ||
                     (w_cls_a == FP_INF && w_cls_b == FP_ZERO)) begin
            w_spec_val = QNAN_P[DATA_WIDTH-1:0];
            w_spec_flags[FLAG_INVALID] = 1'b1;
        end else if (w_cls_a == FP_INF || w_cls_b == FP_INF) begin
            w_spec_val = {w_sign, INF_P[DATA_WIDTH-2:0]};
        end else if (w_cls_a == FP_ZERO || w_cls_b == FP_ZERO) begin
            w_spec_val = {w_sign, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            w_special = 1'b0;
        end
    end

    // Stage 1 register: capture operands on accept; a low in_valid inserts a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid <= 1'b0;
        end else if (w_adv) begin
            r1_valid      <= in_valid;
            r1_sign       <= w_sign;
            r1_exp        <= w_exp_sum;
            r1_sig_a      <= {1'b1, w_man_a};
            r1_sig_b      <= {1'b1, w_man_b};
            r1_special    <= w_special;
            r1_spec_val   <= w_spec_val;
            r1_spec_flags <= w_spec_flags;
        end
    end

    assign w_prod = PW'(r1_sig_a) * PW'(r1_sig_b);

    // Stage 2 register: full-width significand product
    always_ff @(posedge clk) begin
        if (rst) begin
            r2_valid <= 1'b0;
        end else if (w_adv) begin
            r2_valid      <= r1_valid;
            r2_sign       <= r1_sign;
            r2_exp        <= r1_exp;
            r2_prod       <= w_prod;
            r2_special    <= r1_special;
            r2_spec_val   <= r1_spec_val;
            r2_spec_flags <= r1_spec_flags;
        end
    end

    fp_round_pack #(
        .EXP_WIDTH  (EXP_WIDTH),
        .MANT_WIDTH (MANT_WIDTH)
    ) u_round_pack (
        .i_sign          (r2_sign),
        .i_exp           (r2_exp),
        .i_prod          (r2_prod),
        .i_special       (r2_special),
        .i_special_val   (r2_spec_val),
        .i_special_flags (r2_spec_flags),
        .o_result        (w_result),
        .o_flags         (w_flags)
    );

    // Stage 3 register: output holding register, loaded only with real results
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_out_product <= '0;
            r_out_flags   <= '0;
        end else if (w_adv) begin
            r_out_valid <= r2_valid;
            if (r2_valid) begin
                r_out_product <= w_result;
                r_out_flags   <= w_flags;
            end
        end
    end

endmodule

// File: tb/tb_fp_multiply_pipe.sv
// tb_fp_multiply_pipe: directed and randomized checks of fp_multiply_pipe
// against an integer-arithmetic single-precision reference model.
module tb_fp_multiply_pipe;

`ifdef FPM_ROUND_NEAREST_EN
    localparam bit ROUND_NEAREST = 1'b1;
`else
    localparam bit ROUND_NEAREST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_product;
    logic [2:0]  out_flags;

    int n_vec  = 0;
    int n_miss = 0;
    logic [34:0] exp_q[$];

    fp_multiply_pipe #(.EXP_WIDTH(8), .MANT_WIDTH(23)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_flags   (out_flags)
    );

    always #5 clk = ~clk;

    // Reference: {invalid, overflow, underflow, product} from plain integer math
    function automatic logic [34:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int ea, eb, e, sh;
        logic s;
        longint unsigned ma, mb, prod, q;
        bit a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        if (a_nan || b_nan) return {3'b000, 32'h7FC00000};
        if ((a_zero && b_inf) || (a_inf && b_zero)) return {3'b100, 32'h7FC00000};
        if (a_inf || b_inf) return {3'b000, s, 31'h7F800000};
        if (a_zero || b_zero) return {3'b000, s, 31'h0};
        ma   = 64'(a[22:0]) + (64'd1 << 23);
        mb   = 64'(b[22:0]) + (64'd1 << 23);
        prod = ma * mb;
        e    = ea + eb - 127;
        if (prod >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
        end else begin
            sh = 23;
        end
        q = prod >> sh;
        if (ROUND_NEAREST) begin
            longint unsigned rem, half;
            rem  = prod - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
        end
        if (e >= 255) return ROUND_NEAREST ? {3'b010, s, 31'h7F800000} : {3'b010, s, 31'h7F7FFFFF};
        if (e <= 0) return {3'b001, s, 31'h0};
        return {3'b000, s, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rand_normal();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
    endfunction

    function automatic logic [31:0] rand_operand();
        int k;
        logic [31:0] v;
        k = $urandom_range(0, 19);
        v = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
        case (k)
            0: v[30:23] = 8'h00;
            1: v = {v[31], 8'hFF, 23'h0};
            2: v = {v[31], 8'hFF, 23'($urandom) | 23'h1};
            3: v[30:23] = 8'($urandom_range(1, 8));
            4: v[30:23] = 8'($urandom_range(246, 254));
            default: ;
        endcase
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_vec++; if (out_product !== 32'h0) begin n_miss++; $display("FAIL reset_out_product: got %h expected 00000000", out_product); end
        n_vec++; if (out_flags !== 3'b000) begin n_miss++; $display("FAIL reset_out_flags: got %b expected 000", out_flags); end
        n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [31:0] ta[9];
        logic [31:0] tb_op[9];
        logic [31:0] tp[9];
        logic [2:0]  tf[9];
        int lat;
        bit seen;
        ta    = '{32'h40000000, 32'hC1560000, 32'h00000000, 32'h00000000, 32'h7F000000,
                  32'h00800000, 32'h3FC00001, 32'h7FC00000, 32'hFF800000};
        tb_op = '{32'h40400000, 32'h40000000, 32'hC0000000, 32'h7F800000, 32'h7F000000,
                  32'h3F000000, 32'h3FC00001, 32'h3F800000, 32'h40000000};
        tp    = '{32'h40C00000, 32'hC1D60000, 32'h80000000, 32'h7FC00000,
                  ROUND_NEAREST ? 32'h7F800000 : 32'h7F7FFFFF,
                  32'h00000000,
                  ROUND_NEAREST ? 32'h40100002 : 32'h40100001,
                  32'h7FC00000, 32'hFF800000};
        tf    = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000};
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            in_a = ta[i];
            in_b = tb_op[i];
            in_valid = 1'b1;
            out_ready = 1'b1;
            lat = 0;
            seen = 1'b0;
            while (!seen && lat < 10) begin
                @(posedge clk); #1;
                lat++;
                in_valid = 1'b0;
                if (out_valid) seen = 1'b1;
            end
            n_vec++; if (lat !== 3) begin n_miss++; $display("FAIL directed_latency[%0d]: got %0d cycles expected 3", i, lat); end
            n_vec++; if (out_product !== tp[i]) begin n_miss++; $display("FAIL directed_product[%0d]: got %h expected %h", i, out_product, tp[i]); end
            n_vec++; if (out_flags !== tf[i]) begin n_miss++; $display("FAIL directed_flags[%0d]: got %b expected %b", i, out_flags, tf[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int sent, got, cyc, extra;
        bit accepted;
        logic [34:0] expv;
        exp_q.delete();
        sent = 0; got = 0; cyc = 0; extra = 0;
        @(posedge clk); #1;
        in_a = rand_normal();
        in_b = rand_normal();
        in_valid = 1'b1;
        while (got < 10 && cyc < 200) begin
            out_ready = !(cyc >= 4 && cyc <= 8);
            @(negedge clk);
            if (out_valid && !out_ready) begin
                n_vec++; if (in_ready !== 1'b0) begin n_miss++; $display("FAIL b2b_stall_in_ready: got %b expected 0 at cycle %0d", in_ready, cyc); end
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_miss++; $display("FAIL b2b_unexpected: got %h expected no result", out_product);
                end else begin
                    expv = exp_q.pop_front();
                    if ({out_flags, out_product} !== expv) begin n_miss++; $display("FAIL b2b_result[%0d]: got %h expected %h", got, {out_flags, out_product}, expv); end
                end
                got++;
            end
            accepted = in_valid && in_ready;
            if (accepted) exp_q.push_back(ref_mul(in_a, in_b));
            @(posedge clk); #1;
            cyc++;
            if (accepted) begin
                sent++;
                if (sent < 10) begin
                    in_a = rand_normal();
                    in_b = rand_normal();
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        n_vec++; if (got !== 10) begin n_miss++; $display("FAIL b2b_count: got %0d expected 10", got); end
        n_vec++; if (sent !== 10) begin n_miss++; $display("FAIL b2b_sent: got %0d expected 10", sent); end
        n_vec++; if (extra !== 0) begin n_miss++; $display("FAIL b2b_duplicate: got %0d extra expected 0", extra); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] a3, b3;
        logic [34:0] expv;
        int first, n_seen;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_a = 32'h40000000; in_b = 32'h40400000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_a = 32'hC1560000; in_b = 32'h40000000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        a3 = rand_normal();
        b3 = rand_normal();
        expv = ref_mul(a3, b3);
        in_a = a3; in_b = b3; in_valid = 1'b1;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        first = -1;
        n_seen = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (out_valid) begin
                n_seen++;
                if (first < 0) first = c;
                n_vec++; if ({out_flags, out_product} !== expv) begin n_miss++; $display("FAIL midrst_result: got %h expected %h", {out_flags, out_product}, expv); end
            end
        end
        n_vec++; if (first !== 3) begin n_miss++; $display("FAIL midrst_latency: got %0d expected 3", first); end
        n_vec++; if (n_seen !== 1) begin n_miss++; $display("FAIL midrst_count: got %0d expected 1", n_seen); end
    endtask

    task automatic test_random_stream();
        int sent, got, cyc;
        bit accepted;
        logic [34:0] expv;
        exp_q.delete();
        sent = 0; got = 0; cyc = 0;
        accepted = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (got < 300 && cyc < 4000) begin
            out_ready = ($urandom_range(0, 9) < 6);
            if (!in_valid || accepted) begin
                if (sent < 300 && $urandom_range(0, 9) < 7) begin
                    in_valid = 1'b1;
                    in_a = rand_operand();
                    in_b = rand_operand();
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            n_vec++; if (in_ready !== (!out_valid || out_ready)) begin n_miss++; $display("FAIL rand_in_ready: got %b expected %b", in_ready, (!out_valid || out_ready)); end
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_miss++; $display("FAIL rand_unexpected: got %h expected no result", out_product);
                end else begin
                    expv = exp_q.pop_front();
                    if ({out_flags, out_product} !== expv) begin n_miss++; $display("FAIL rand_result[%0d]: got %h expected %h", got, {out_flags, out_product}, expv); end
                end
                got++;
            end
            accepted = in_valid && in_ready;
            if (accepted) begin
                exp_q.push_back(ref_mul(in_a, in_b));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        n_vec++; if (got !== 300) begin n_miss++; $display("FAIL rand_count: got %0d expected 300", got); end
        n_vec++; if (exp_q.size() !== 0) begin n_miss++; $display("FAIL rand_leftover: got %0d expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_mid_reset();
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
